// File: rtl/mem_ctrl.sv
// mem_ctrl: bridges the CPU single-cycle-strobe memory port to an asynchronous
// 16-bit SRAM, stretching each access by WAIT_STATES extra cycles.
module mem_ctrl #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_read,
  input  logic              ram_write,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       mem_data,
  output logic              mem_busy,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dout,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic                is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                active_d;

  // Next state, latches, and strobes decoded from the state being entered so
  // every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (ram_write || ram_read) begin
          addr_d  = addr[ADDR_W-1:0];
          dout_d  = wdata;
          is_wr_d = ram_write;
          state_d = SETUP;
        end
      end
      SETUP: begin
        wcnt_d  = CNT_W'(WAIT_STATES);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (wcnt_q == '0) begin
          state_d = DONE;
          if (!is_wr_q) rdata_d = sram_din;
        end else begin
          wcnt_d = wcnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    active_d = (state_d == SETUP) || (state_d == ACCESS);
    busy_d   = active_d;
    ready_d  = (state_d == DONE);
    ce_n_d   = !active_d;
    oe_n_d   = !((state_d == ACCESS) && !is_wr_d);
    we_n_d   = !((state_d == ACCESS) && is_wr_d);
    dq_oe_d  = active_d && is_wr_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign mem_data   = rdata_q;
  assign mem_busy   = busy_q;
  assign mem_ready  = ready_q;
  assign sram_addr  = addr_q;
  assign sram_dout  = dout_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl; one instance with 2 wait states,
// one with 0, both sharing CPU-side stimulus and each with its own SRAM model.
module tb_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ram_read, ram_write;
  logic [15:0] addr, wdata;

  logic [15:0] mem_data, sram_addr, sram_dout, sram_din;
  logic        mem_busy, mem_ready, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  logic [15:0] z_mem_data, z_sram_addr, z_sram_dout, z_sram_din;
  logic        z_mem_busy, z_mem_ready, z_sram_dq_oe, z_sram_ce_n, z_sram_oe_n, z_sram_we_n;

  mem_ctrl #(.WAIT_STATES(2), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .ram_read(ram_read), .ram_write(ram_write),
    .addr(addr), .wdata(wdata), .mem_data(mem_data), .mem_busy(mem_busy),
    .mem_ready(mem_ready), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .sram_dq_oe(sram_dq_oe), .sram_din(sram_din), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  mem_ctrl #(.WAIT_STATES(0), .ADDR_W(16)) dut_z (
    .clk(clk), .rst(rst), .ram_read(ram_read), .ram_write(ram_write),
    .addr(addr), .wdata(wdata), .mem_data(z_mem_data), .mem_busy(z_mem_busy),
    .mem_ready(z_mem_ready), .sram_addr(z_sram_addr), .sram_dout(z_sram_dout),
    .sram_dq_oe(z_sram_dq_oe), .sram_din(z_sram_din), .sram_ce_n(z_sram_ce_n),
    .sram_oe_n(z_sram_oe_n), .sram_we_n(z_sram_we_n)
  );

  // SRAM models: unwritten locations read back as 0xC300 | address.
  logic [15:0] mem_a [0:255];
  logic        wr_a  [0:255];
  logic [15:0] mem_z [0:255];
  logic        wr_z  [0:255];

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      mem_a[sram_addr[7:0]] <= sram_dout;
      wr_a[sram_addr[7:0]]  <= 1'b1;
    end
    if (!z_sram_ce_n && !z_sram_we_n && z_sram_dq_oe) begin
      mem_z[z_sram_addr[7:0]] <= z_sram_dout;
      wr_z[z_sram_addr[7:0]]  <= 1'b1;
    end
  end

  always_comb begin
    sram_din = 16'hDEAD;
    if (!sram_ce_n && !sram_oe_n)
      sram_din = (wr_a[sram_addr[7:0]] === 1'b1) ? mem_a[sram_addr[7:0]] : (16'hC300 | sram_addr);
    z_sram_din = 16'hDEAD;
    if (!z_sram_ce_n && !z_sram_oe_n)
      z_sram_din = (wr_z[z_sram_addr[7:0]] === 1'b1) ? mem_z[z_sram_addr[7:0]] : (16'hC300 | z_sram_addr);
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] sb_q[$];
  logic [15:0] z_sb_q[$];
  logic [15:0] last_rd = 16'h0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the CPU port and wait (bounded) for mem_ready.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, output logic [15:0] got,
                         output int lat, output int we_cycles, output logic saw_oe);
    ram_read = rd; ram_write = wr; addr = a; wdata = d;
    lat = -1; got = '0; we_cycles = 0; saw_oe = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin
        ram_read = 1'b0; ram_write = 1'b0; addr = ~a; wdata = ~d;
      end
      if (!sram_we_n) we_cycles++;
      if (!sram_oe_n) saw_oe = 1'b1;
      if (mem_ready) begin
        got = mem_data;
        lat = c;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; ram_read = 1'b0; ram_write = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({mem_busy, mem_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 6'b001110) begin
      n_err++;
      $display("FAIL reset_ctl got=%b exp=001110",
               {mem_busy, mem_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
    end
    n_vec++;
    if ({mem_data, sram_addr, sram_dout} !== 48'h0) begin
      n_err++;
      $display("FAIL reset_data got=%h exp=0", {mem_data, sram_addr, sram_dout});
    end
    n_vec++;
    if ({z_mem_busy, z_mem_ready, z_sram_ce_n, z_sram_oe_n, z_sram_we_n, z_sram_dq_oe, z_mem_data} !== {6'b001110, 16'h0}) begin
      n_err++;
      $display("FAIL reset_ws0 got=%b/%h exp=001110/0000",
               {z_mem_busy, z_mem_ready, z_sram_ce_n, z_sram_oe_n, z_sram_we_n, z_sram_dq_oe}, z_mem_data);
    end
    tick();
    last_rd = 16'h0000;
  endtask

  task automatic test_write_timing();
    logic [5:0]  exp_ctl;
    logic [15:0] exp_md;
    int          we_cnt;
    bit          in_busy;
    we_cnt = 0;
    ram_write = 1'b1; addr = 16'h1234; wdata = 16'hBEEF;
    sb_q.push_back(last_rd);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin
        ram_write = 1'b0; addr = 16'hFFFF; wdata = 16'h0000;
      end
      in_busy = (c >= 1) && (c <= 4);
      exp_ctl = {in_busy, c == 5, !in_busy, 1'b1, !((c >= 2) && (c <= 4)), in_busy};
      n_vec++;
      if ({mem_busy, mem_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== exp_ctl) begin
        n_err++;
        $display("FAIL wr_timing_c%0d got=%b exp=%b", c,
                 {mem_busy, mem_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, exp_ctl);
      end
      if (!sram_we_n) begin
        we_cnt++;
        n_vec++;
        if ({sram_addr, sram_dout} !== {16'h1234, 16'hBEEF}) begin
          n_err++;
          $display("FAIL wr_bus_c%0d got=%h exp=1234beef", c, {sram_addr, sram_dout});
        end
      end
      if (mem_ready) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_sb_empty got=ready exp=none");
        end else begin
          exp_md = sb_q.pop_front();
          if (mem_data !== exp_md) begin
            n_err++;
            $display("FAIL wr_mem_data got=%h exp=%h", mem_data, exp_md);
          end
        end
      end
    end
    n_vec++;
    if (we_cnt != 3 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL wr_we_cycles got=%0d/%0d exp=3/0", we_cnt, sb_q.size());
    end
  endtask

  task automatic test_readback();
    logic [15:0] got, exp_md;
    int          lat, wec;
    logic        so;
    sb_q.push_back(last_rd);
    run_txn(1'b0, 1'b1, 16'h0010, 16'hA5A5, got, lat, wec, so);
    exp_md = sb_q.pop_front();
    n_vec++;
    if (lat != 5 || got !== exp_md) begin
      n_err++;
      $display("FAIL rb_write got=lat%0d/%h exp=lat5/%h", lat, got, exp_md);
    end
    sb_q.push_back(16'hA5A5);
    last_rd = 16'hA5A5;
    run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, got, lat, wec, so);
    exp_md = sb_q.pop_front();
    n_vec++;
    if (lat != 5 || got !== exp_md) begin
      n_err++;
      $display("FAIL rb_read got=lat%0d/%h exp=lat5/%h", lat, got, exp_md);
    end
    repeat (3) tick();
    n_vec++;
    if (mem_data !== 16'hA5A5 || mem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rb_hold got=%h/%b exp=a5a5/0", mem_data, mem_ready);
    end
  endtask

  task automatic test_both_strobes();
    logic [15:0] got, exp_md;
    int          lat, wec;
    logic        so;
    sb_q.push_back(last_rd);
    run_txn(1'b1, 1'b1, 16'h0030, 16'h7777, got, lat, wec, so);
    exp_md = sb_q.pop_front();
    n_vec++;
    if (lat != 5 || wec != 3 || so !== 1'b0 || got !== exp_md) begin
      n_err++;
      $display("FAIL both_write got=lat%0d/we%0d/oe%b/%h exp=lat5/we3/oe0/%h",
               lat, wec, so, got, exp_md);
    end
    sb_q.push_back(16'h7777);
    last_rd = 16'h7777;
    run_txn(1'b1, 1'b0, 16'h0030, 16'h0000, got, lat, wec, so);
    exp_md = sb_q.pop_front();
    n_vec++;
    if (got !== exp_md || wec != 0) begin
      n_err++;
      $display("FAIL both_readback got=%h/we%0d exp=%h/we0", got, wec, exp_md);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got, exp_md;
    int          lat, wec, rdy_cnt;
    logic        so;
    ram_write = 1'b1; addr = 16'h0020; wdata = 16'h1111;
    tick();
    ram_write = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    tick();
    n_vec++;
    if (sram_we_n !== 1'b0) begin
      n_err++;
      $display("FAIL mid_pre_we got=%b exp=0", sram_we_n);
    end
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if ({sram_ce_n, sram_we_n, sram_dq_oe, mem_busy, mem_ready} !== 5'b11000) begin
      n_err++;
      $display("FAIL mid_abort got=%b exp=11000",
               {sram_ce_n, sram_we_n, sram_dq_oe, mem_busy, mem_ready});
    end
    sb_q.delete();
    z_sb_q.delete();
    last_rd = 16'h0000;
    rdy_cnt = 0;
    repeat (2) begin
      tick();
      if (mem_ready) rdy_cnt++;
    end
    rst = 1'b1;
    repeat (6) begin
      tick();
      if (mem_ready) rdy_cnt++;
    end
    n_vec++;
    if (rdy_cnt != 0) begin
      n_err++;
      $display("FAIL mid_no_ready got=%0d exp=0", rdy_cnt);
    end
    sb_q.push_back(last_rd);
    run_txn(1'b0, 1'b1, 16'h0020, 16'h2222, got, lat, wec, so);
    exp_md = sb_q.pop_front();
    n_vec++;
    if (lat != 5 || wec != 3 || got !== exp_md) begin
      n_err++;
      $display("FAIL mid_next_wr got=lat%0d/we%0d/%h exp=lat5/we3/%h", lat, wec, got, exp_md);
    end
    sb_q.push_back(16'h2222);
    last_rd = 16'h2222;
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, got, lat, wec, so);
    exp_md = sb_q.pop_front();
    n_vec++;
    if (lat != 5 || got !== exp_md) begin
      n_err++;
      $display("FAIL mid_next_rd got=lat%0d/%h exp=lat5/%h", lat, got, exp_md);
    end
  endtask

  task automatic test_back_to_back_ws0();
    logic [1:0]  exp_ctl;
    logic [15:0] exp_md;
    z_sb_q.push_back(16'hC301);
    z_sb_q.push_back(16'hC302);
    ram_read = 1'b1; addr = 16'h0001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) addr = 16'h0002;
      if (c == 8) ram_read = 1'b0;
      exp_ctl = {(c == 1) || (c == 2) || (c == 5) || (c == 6), (c == 3) || (c == 7)};
      n_vec++;
      if ({z_mem_busy, z_mem_ready} !== exp_ctl) begin
        n_err++;
        $display("FAIL ws0_ctl_c%0d got=%b exp=%b", c, {z_mem_busy, z_mem_ready}, exp_ctl);
      end
      if (z_mem_ready) begin
        n_vec++;
        if (z_sb_q.size() == 0) begin
          n_err++;
          $display("FAIL ws0_sb_empty_c%0d got=ready exp=none", c);
        end else begin
          exp_md = z_sb_q.pop_front();
          if (z_mem_data !== exp_md) begin
            n_err++;
            $display("FAIL ws0_data_c%0d got=%h exp=%h", c, z_mem_data, exp_md);
          end
        end
      end
    end
    n_vec++;
    if (z_sb_q.size() != 0) begin
      n_err++;
      $display("FAIL ws0_leftover got=%0d exp=0", z_sb_q.size());
    end
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_readback();
    test_both_strobes();
    test_reset_mid();
    test_back_to_back_ws0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
